coeff_runlevel: RTL and testbench

- Downstream consumer of the 4x4 transform/quantiser stage's processed residual block.
- Reorders the 16 quantised coefficients into zigzag (or field) scan order and computes the CAVLC header values: TotalCoeff, TrailingOnes and TotalZeros.
- Streams (level, run_before) pairs in reverse scan order over a valid/ready handshake to the entropy coder.

---
 rtl/codec_pkg.sv | 30 +++
 rtl/runlevel_scan_stats.sv | 52 +++++
 rtl/coeff_runlevel.sv | 222 ++++++++++++++++++++++
 tb/tb_coeff_runlevel.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared types and constants for the 4x4 coefficient run/level stage.
// Ports: none (package). Scan tables map scan position -> raster index.
// Optional field scan order is selected at the top level under RUNLEVEL_FIELD_SCAN_EN.
package codec_pkg;

    localparam int COEFF_W = 8;

    typedef logic signed [COEFF_W-1:0] coeff_t;

    // Frame zigzag: raster index (row*4+col) for scan positions 0..15
    localparam logic [3:0] ZIGZAG_4X4 [16] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    // Field scan: column-biased order for interlaced content
    localparam logic [3:0] FIELD_4X4 [16] = '{
        4'd0, 4'd4, 4'd1, 4'd8, 4'd12, 4'd5, 4'd9, 4'd13,
        4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [1:0] MAX_TRAILING_ONES = 2'd3;

endpackage

// File: rtl/runlevel_scan_stats.sv
// Purpose: CAVLC header statistics of a scan-ordered 4x4 block.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: scan_coeffs in; total_coeff, last_idx, trailing_ones, total_zeros out.
module runlevel_scan_stats #(
    parameter int COEFF_WIDTH = 8,
    parameter int RUN_WIDTH   = 4
) (
    input  logic signed [COEFF_WIDTH-1:0] scan_coeffs [0:15],
    output logic [4:0]                    total_coeff,
    output logic [3:0]                    last_idx,
    output logic [1:0]                    trailing_ones,
    output logic [RUN_WIDTH-1:0]          total_zeros
);
    import codec_pkg::*;

    logic       counting;
    logic [4:0] span;

    always_comb begin
        total_coeff   = '0;
        last_idx      = '0;
        trailing_ones = '0;
        counting      = 1'b1;
        span          = '0;

        // Ascending walk: the last hit is the highest nonzero scan position
        for (int i = 0; i < 16; i++) begin
            if (scan_coeffs[i] != '0) begin
                total_coeff = total_coeff + 5'd1;
                last_idx    = 4'(i);
            end
        end

        // Walk down from the top; zeros are skipped, the first |level|>1
        // (or hitting the saturation limit) ends the run of trailing ones.
        for (int i = 15; i >= 0; i--) begin
            if (counting && scan_coeffs[i] != '0) begin
                if ((scan_coeffs[i] == COEFF_WIDTH'(1) ||
                     scan_coeffs[i] == {COEFF_WIDTH{1'b1}}) &&
                    trailing_ones < MAX_TRAILING_ONES) begin
                    trailing_ones = trailing_ones + 2'd1;
                end else begin
                    counting = 1'b0;
                end
            end
        end

        span        = {1'b0, last_idx} + 5'd1 - total_coeff;
        total_zeros = (total_coeff == 5'd0) ? '0 : RUN_WIDTH'(span);
    end

endmodule

// File: rtl/coeff_runlevel.sv
// Purpose: scan-reorders a 4x4 quantised block, registers CAVLC header values and
//          streams (level, run_before) pairs highest scan position first.
// Latency: block accepted in cycle N -> first out_valid in cycle N+2 (one SCAN cycle).
// Backpressure: out_* held while out_valid && !out_ready; in_ready only in IDLE or on
//               the last-beat handshake, so back-to-back blocks need no idle cycle.
// Ports: clk/reset (sync, active-high); in_valid/in_ready/coeffs[16] (raster order);
//        out_valid/out_ready/out_level/out_run/out_t1/out_last; total_coeff,
//        trailing_ones, total_zeros headers. RUNLEVEL_FIELD_SCAN_EN adds field_scan.
module coeff_runlevel #(
    parameter int COEFF_WIDTH = 8,
    parameter int RUN_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [COEFF_WIDTH-1:0] coeffs [0:15],
`ifdef RUNLEVEL_FIELD_SCAN_EN
    input  logic                          field_scan,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [COEFF_WIDTH-1:0] out_level,
    output logic [RUN_WIDTH-1:0]          out_run,
    output logic                          out_t1,
    output logic                          out_last,
    output logic [4:0]                    total_coeff,
    output logic [1:0]                    trailing_ones,
    output logic [RUN_WIDTH-1:0]          total_zeros
);
    import codec_pkg::*;

    state_t                         state_q, state_d;
    logic signed [COEFF_WIDTH-1:0]  scan_q [0:15];
    logic signed [COEFF_WIDTH-1:0]  scan_d [0:15];
    logic signed [COEFF_WIDTH-1:0]  scan_in [0:15];
    logic [3:0]                     cursor_q, cursor_d;
    logic [4:0]                     beat_idx_q, beat_idx_d;
    logic                           out_valid_q, out_valid_d;
    logic signed [COEFF_WIDTH-1:0]  out_level_q, out_level_d;
    logic [RUN_WIDTH-1:0]           out_run_q, out_run_d;
    logic                           out_t1_q, out_t1_d;
    logic                           out_last_q, out_last_d;
    logic [4:0]                     total_coeff_q, total_coeff_d;
    logic [1:0]                     trailing_ones_q, trailing_ones_d;
    logic [RUN_WIDTH-1:0]           total_zeros_q, total_zeros_d;

    logic                           field_sel;
    logic                           accept;
    logic [4:0]                     stat_tc;
    logic [3:0]                     stat_last;
    logic [1:0]                     stat_t1;
    logic [RUN_WIDTH-1:0]           stat_tz;
    logic [3:0]                     adv_idx;
    logic [3:0]                     sel_cur;
    logic                           nxt_has;
    logic [3:0]                     nxt_idx;
    logic signed [COEFF_WIDTH-1:0]  beat_level;
    logic [RUN_WIDTH-1:0]           beat_run;
    logic                           beat_last;

`ifdef RUNLEVEL_FIELD_SCAN_EN
    assign field_sel = field_scan;
`else
    assign field_sel = 1'b0;
`endif

    assign in_ready = (state_q == IDLE) ||
                      (state_q == EMIT && out_valid_q && out_ready && out_last_q);
    assign accept   = in_valid && in_ready;

    // Raster -> scan reorder of the incoming block
    always_comb begin
        for (int p = 0; p < 16; p++) begin
            scan_in[p] = coeffs[field_sel ? FIELD_4X4[p] : ZIGZAG_4X4[p]];
        end
    end

    runlevel_scan_stats #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .RUN_WIDTH   (RUN_WIDTH)
    ) u_stats (
        .scan_coeffs   (scan_q),
        .total_coeff   (stat_tc),
        .last_idx      (stat_last),
        .trailing_ones (stat_t1),
        .total_zeros   (stat_tz)
    );

    // Next lower nonzero below the current cursor (where the cursor moves on a handshake).
    // Only used when the current beat is not last, so a hit is guaranteed there.
    always_comb begin
        adv_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) < cursor_q && scan_q[i] != '0) begin
                adv_idx = 4'(i);
            end
        end
    end

    // Fields of the beat about to be loaded: first beat at L during SCAN,
    // otherwise the beat at the advanced cursor.
    always_comb begin
        sel_cur = (state_q == SCAN) ? stat_last : adv_idx;
        nxt_has = 1'b0;
        nxt_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) < sel_cur && scan_q[i] != '0) begin
                nxt_has = 1'b1;
                nxt_idx = 4'(i);
            end
        end
        beat_level = scan_q[sel_cur];
        // With no lower nonzero, every position below the cursor is a zero
        beat_run   = nxt_has ? RUN_WIDTH'(sel_cur - nxt_idx - 4'd1) : RUN_WIDTH'(sel_cur);
        beat_last  = !nxt_has;
    end

    always_comb begin
        state_d         = state_q;
        scan_d          = scan_q;
        cursor_d        = cursor_q;
        beat_idx_d      = beat_idx_q;
        out_valid_d     = out_valid_q;
        out_level_d     = out_level_q;
        out_run_d       = out_run_q;
        out_t1_d        = out_t1_q;
        out_last_d      = out_last_q;
        total_coeff_d   = total_coeff_q;
        trailing_ones_d = trailing_ones_q;
        total_zeros_d   = total_zeros_q;

        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (accept) begin
                    scan_d  = scan_in;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                total_coeff_d   = stat_tc;
                trailing_ones_d = stat_t1;
                total_zeros_d   = stat_tz;
                cursor_d        = stat_last;
                beat_idx_d      = '0;
                out_valid_d     = 1'b1;
                out_level_d     = beat_level;
                out_run_d       = beat_run;
                out_last_d      = beat_last;
                out_t1_d        = (stat_t1 != 2'd0);
                state_d         = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        if (in_valid) begin
                            scan_d  = scan_in;
                            state_d = SCAN;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cursor_d    = adv_idx;
                        beat_idx_d  = beat_idx_q + 5'd1;
                        out_level_d = beat_level;
                        out_run_d   = beat_run;
                        out_last_d  = beat_last;
                        out_t1_d    = (beat_idx_q + 5'd1) < {3'b000, trailing_ones_q};
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            for (int i = 0; i < 16; i++) begin
                scan_q[i] <= '0;
            end
            cursor_q        <= '0;
            beat_idx_q      <= '0;
            out_valid_q     <= 1'b0;
            out_level_q     <= '0;
            out_run_q       <= '0;
            out_t1_q        <= 1'b0;
            out_last_q      <= 1'b0;
            total_coeff_q   <= '0;
            trailing_ones_q <= '0;
            total_zeros_q   <= '0;
        end else begin
            state_q         <= state_d;
            scan_q          <= scan_d;
            cursor_q        <= cursor_d;
            beat_idx_q      <= beat_idx_d;
            out_valid_q     <= out_valid_d;
            out_level_q     <= out_level_d;
            out_run_q       <= out_run_d;
            out_t1_q        <= out_t1_d;
            out_last_q      <= out_last_d;
            total_coeff_q   <= total_coeff_d;
            trailing_ones_q <= trailing_ones_d;
            total_zeros_q   <= total_zeros_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_level     = out_level_q;
    assign out_run       = out_run_q;
    assign out_t1        = out_t1_q;
    assign out_last      = out_last_q;
    assign total_coeff   = total_coeff_q;
    assign trailing_ones = trailing_ones_q;
    assign total_zeros   = total_zeros_q;

endmodule

// File: tb/tb_coeff_runlevel.sv
// Directed bench for coeff_runlevel: reset, all-zero, mixed levels, -128 at the
// last position, trailing-ones saturation, backpressure hold, back-to-back and
// reset during EMIT. Inputs driven 1 time unit after posedge, outputs sampled there.
module tb_coeff_runlevel;
    import codec_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    coeff_t      coeffs [0:15];
    logic        out_valid;
    logic        out_ready;
    coeff_t      out_level;
    logic [3:0]  out_run;
    logic        out_t1;
    logic        out_last;
    logic [4:0]  total_coeff;
    logic [1:0]  trailing_ones;
    logic [3:0]  total_zeros;
`ifdef RUNLEVEL_FIELD_SCAN_EN
    logic        field_scan = 1'b0;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   b_lv [8];
    int   b_rn [8];
    logic b_t1 [8];
    logic b_ls [8];

    always #5 clk = ~clk;

    coeff_runlevel #(.COEFF_WIDTH(8), .RUN_WIDTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .coeffs        (coeffs),
`ifdef RUNLEVEL_FIELD_SCAN_EN
        .field_scan    (field_scan),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_level     (out_level),
        .out_run       (out_run),
        .out_t1        (out_t1),
        .out_last      (out_last),
        .total_coeff   (total_coeff),
        .trailing_ones (trailing_ones),
        .total_zeros   (total_zeros)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_coeffs();
        for (int i = 0; i < 16; i++) coeffs[i] = '0;
    endtask

    // Present the block and wait (bounded) for the accepting edge.
    task automatic send_block();
        int w = 0;
        in_valid = 1'b1;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Drain one block with out_ready high; fw = edges until first valid beat.
    task automatic collect(output int nb, output int fw);
        int w = 0;
        nb = 0;
        fw = -1;
        out_ready = 1'b1;
        while (w < 40 && nb < 8) begin
            @(posedge clk); #1; w++;
            if (out_valid) begin
                if (fw < 0) fw = w;
                b_lv[nb] = int'(out_level);
                b_rn[nb] = int'(out_run);
                b_t1[nb] = out_t1;
                b_ls[nb] = out_last;
                nb++;
                if (out_last) break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_coeffs();
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_checks++; if (out_level !== 8'sd0 || out_run !== 4'd0 || out_t1 !== 1'b0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_beat_fields got lv=%0d run=%0d t1=%0b last=%0b want 0", out_level, out_run, out_t1, out_last); end
        n_checks++; if (total_coeff !== 5'd0 || trailing_ones !== 2'd0 || total_zeros !== 4'd0) begin
            n_fail++; $display("FAIL reset_headers got tc=%0d t1=%0d tz=%0d want 0", total_coeff, trailing_ones, total_zeros); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_all_zero();
        int nb, fw;
        clear_coeffs();
        send_block();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_scan_cycle_valid got %0b want 0", out_valid); end
        collect(nb, fw);
        n_checks++; if (fw !== 1) begin n_fail++; $display("FAIL zero_latency got %0d edges want 1", fw); end
        n_checks++; if (nb !== 1) begin n_fail++; $display("FAIL zero_beats got %0d want 1", nb); end
        n_checks++; if (b_lv[0] !== 0 || b_rn[0] !== 0 || b_t1[0] !== 1'b0 || b_ls[0] !== 1'b1) begin
            n_fail++; $display("FAIL zero_beat got lv=%0d run=%0d t1=%0b last=%0b want 0,0,0,1", b_lv[0], b_rn[0], b_t1[0], b_ls[0]); end
        n_checks++; if (total_coeff !== 5'd0 || trailing_ones !== 2'd0 || total_zeros !== 4'd0) begin
            n_fail++; $display("FAIL zero_headers got tc=%0d t1=%0d tz=%0d want 0,0,0", total_coeff, trailing_ones, total_zeros); end
    endtask

    task automatic test_mixed();
        int nb, fw;
        clear_coeffs();
        coeffs[0] = 8'sd5; coeffs[1] = -8'sd1; coeffs[4] = 8'sd1;
        send_block();
        collect(nb, fw);
        n_checks++; if (nb !== 3) begin n_fail++; $display("FAIL mixed_beats got %0d want 3", nb); end
        n_checks++; if (b_lv[0] !== 1 || b_rn[0] !== 0 || b_t1[0] !== 1'b1 || b_ls[0] !== 1'b0) begin
            n_fail++; $display("FAIL mixed_beat0 got lv=%0d run=%0d t1=%0b last=%0b want 1,0,1,0", b_lv[0], b_rn[0], b_t1[0], b_ls[0]); end
        n_checks++; if (b_lv[1] !== -1 || b_rn[1] !== 0 || b_t1[1] !== 1'b1 || b_ls[1] !== 1'b0) begin
            n_fail++; $display("FAIL mixed_beat1 got lv=%0d run=%0d t1=%0b last=%0b want -1,0,1,0", b_lv[1], b_rn[1], b_t1[1], b_ls[1]); end
        n_checks++; if (b_lv[2] !== 5 || b_rn[2] !== 0 || b_t1[2] !== 1'b0 || b_ls[2] !== 1'b1) begin
            n_fail++; $display("FAIL mixed_beat2 got lv=%0d run=%0d t1=%0b last=%0b want 5,0,0,1", b_lv[2], b_rn[2], b_t1[2], b_ls[2]); end
        n_checks++; if (total_coeff !== 5'd3 || trailing_ones !== 2'd2 || total_zeros !== 4'd0) begin
            n_fail++; $display("FAIL mixed_headers got tc=%0d t1=%0d tz=%0d want 3,2,0", total_coeff, trailing_ones, total_zeros); end
    endtask

    task automatic test_single_min();
        int nb, fw;
        clear_coeffs();
        coeffs[15] = -8'sd128;
        send_block();
        collect(nb, fw);
        n_checks++; if (nb !== 1) begin n_fail++; $display("FAIL min_beats got %0d want 1", nb); end
        n_checks++; if (b_lv[0] !== -128 || b_rn[0] !== 15 || b_t1[0] !== 1'b0 || b_ls[0] !== 1'b1) begin
            n_fail++; $display("FAIL min_beat got lv=%0d run=%0d t1=%0b last=%0b want -128,15,0,1", b_lv[0], b_rn[0], b_t1[0], b_ls[0]); end
        n_checks++; if (total_coeff !== 5'd1 || trailing_ones !== 2'd0 || total_zeros !== 4'd15) begin
            n_fail++; $display("FAIL min_headers got tc=%0d t1=%0d tz=%0d want 1,0,15", total_coeff, trailing_ones, total_zeros); end
    endtask

    task automatic test_trailing_sat();
        int nb, fw;
        clear_coeffs();
        coeffs[0] = 8'sd1; coeffs[1] = 8'sd1; coeffs[4] = -8'sd1; coeffs[8] = 8'sd1;
        send_block();
        collect(nb, fw);
        n_checks++; if (nb !== 4) begin n_fail++; $display("FAIL sat_beats got %0d want 4", nb); end
        n_checks++; if (trailing_ones !== 2'd3 || total_coeff !== 5'd4 || total_zeros !== 4'd0) begin
            n_fail++; $display("FAIL sat_headers got tc=%0d t1=%0d tz=%0d want 4,3,0", total_coeff, trailing_ones, total_zeros); end
        n_checks++; if (b_lv[0] !== 1 || b_lv[1] !== -1 || b_lv[2] !== 1 || b_lv[3] !== 1) begin
            n_fail++; $display("FAIL sat_levels got %0d,%0d,%0d,%0d want 1,-1,1,1", b_lv[0], b_lv[1], b_lv[2], b_lv[3]); end
        n_checks++; if (b_t1[0] !== 1'b1 || b_t1[1] !== 1'b1 || b_t1[2] !== 1'b1 || b_t1[3] !== 1'b0) begin
            n_fail++; $display("FAIL sat_t1_flags got %0b%0b%0b%0b want 1110", b_t1[0], b_t1[1], b_t1[2], b_t1[3]); end
        n_checks++; if (b_rn[3] !== 0 || b_ls[3] !== 1'b1 || b_ls[2] !== 1'b0) begin
            n_fail++; $display("FAIL sat_last_beat got run=%0d last=%0b prev_last=%0b want 0,1,0", b_rn[3], b_ls[3], b_ls[2]); end
    endtask

    // Scan: pos0=7, pos6=-2 (raster 3), pos9=4 (raster 12) -> L=9, tz=7
    task automatic test_backpressure();
        clear_coeffs();
        coeffs[0] = 8'sd7; coeffs[3] = -8'sd2; coeffs[12] = 8'sd4;
        out_ready = 1'b0;
        send_block();
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_level !== 8'sd4 || out_run !== 4'd2 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL bp_beat0 got v=%0b lv=%0d run=%0d last=%0b want 1,4,2,0", out_valid, out_level, out_run, out_last); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (out_valid !== 1'b1 || out_level !== -8'sd2 || out_run !== 4'd5 || out_t1 !== 1'b0 || out_last !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_c%0d got v=%0b lv=%0d run=%0d t1=%0b last=%0b want 1,-2,5,0,0", c, out_valid, out_level, out_run, out_t1, out_last); end
            if (c < 3) begin @(posedge clk); #1; end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_level !== 8'sd7 || out_run !== 4'd0 || out_last !== 1'b1) begin
            n_fail++; $display("FAIL bp_beat2 got v=%0b lv=%0d run=%0d last=%0b want 1,7,0,1", out_valid, out_level, out_run, out_last); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || total_coeff !== 5'd3 || trailing_ones !== 2'd0 || total_zeros !== 4'd7) begin
            n_fail++; $display("FAIL bp_end got v=%0b tc=%0d t1=%0d tz=%0d want 0,3,0,7", out_valid, total_coeff, trailing_ones, total_zeros); end
    endtask

    task automatic test_back_to_back();
        clear_coeffs();
        coeffs[0] = 8'sd5; coeffs[1] = -8'sd1; coeffs[4] = 8'sd1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;                         // block A accepted
        clear_coeffs(); coeffs[15] = -8'sd128;      // block B waits with in_valid high
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_scan_a got v=%0b rdy=%0b want 0,0", out_valid, in_ready); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b0 || out_level !== -8'sd1) begin
            n_fail++; $display("FAIL b2b_mid_beat got rdy=%0b lv=%0d want 0,-1", in_ready, out_level); end
        @(posedge clk); #1;
        n_checks++; if (out_last !== 1'b1 || out_level !== 8'sd5 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_last_beat got last=%0b lv=%0d rdy=%0b want 1,5,1", out_last, out_level, in_ready); end
        @(posedge clk); #1;                         // block B accepted on A's last beat
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || total_coeff !== 5'd3) begin
            n_fail++; $display("FAIL b2b_scan_b got v=%0b rdy=%0b tc=%0d want 0,0,3", out_valid, in_ready, total_coeff); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_level !== -8'sd128 || out_run !== 4'd15 || total_coeff !== 5'd1 || total_zeros !== 4'd15) begin
            n_fail++; $display("FAIL b2b_beat_b got v=%0b lv=%0d run=%0d tc=%0d tz=%0d want 1,-128,15,1,15", out_valid, out_level, out_run, total_coeff, total_zeros); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || total_coeff !== 5'd0) begin
            n_fail++; $display("FAIL emit_reset got v=%0b rdy=%0b tc=%0d want 0,1,0", out_valid, in_ready, total_coeff); end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_mixed();
        test_single_min();
        test_trailing_sat();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
